// File: rtl/alu_exec_ctrl_if.sv
// Request/completion bus between instruction decode and the execute controller.
// Decode drives the master side; the controller is the slave.
interface alu_exec_ctrl_if #(
   parameter int DATA_W  = 16,
   parameter int RF_AW   = 4,
   parameter int SHAMT_W = 4
);
   logic               req_valid;
   logic               req_ready;
   logic [4:0]         req_op;
   logic [RF_AW-1:0]   req_rdest;
   logic [RF_AW-1:0]   req_rsrc;
   logic [DATA_W-1:0]  req_imm;
   logic               req_use_imm;
   logic [SHAMT_W-1:0] req_shamt;
   logic               done;
   logic               err;

   modport master (
      output req_valid, req_op, req_rdest, req_rsrc, req_imm, req_use_imm, req_shamt,
      input  req_ready, done, err
   );

   modport slave (
      input  req_valid, req_op, req_rdest, req_rsrc, req_imm, req_use_imm, req_shamt,
      output req_ready, done, err
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller: reads operands, drives the ALU (iterating
// single-bit shifts), writes the result back and maintains the PSR flags.
module alu_exec_ctrl #(
   parameter int DATA_W  = 16,
   parameter int RF_AW   = 4,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   alu_exec_ctrl_if.slave     req,
   output logic [RF_AW-1:0]   rf_raddr_a,
   output logic [RF_AW-1:0]   rf_raddr_b,
   input  logic [DATA_W-1:0]  rf_rdata_a,
   input  logic [DATA_W-1:0]  rf_rdata_b,
   output logic               rf_we,
   output logic [RF_AW-1:0]   rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic [DATA_W-1:0]  alu_rsrc,
   output logic [DATA_W-1:0]  alu_rdest,
   output logic [4:0]         alu_op,
   input  logic [DATA_W-1:0]  alu_out,
   input  logic [4:0]         alu_flags,
   output logic [4:0]         psr
);
   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_CMP  = 5'd2;
   localparam logic [4:0] OP_LSH  = 5'd7;
   localparam logic [4:0] OP_ARSH = 5'd9;
   // CMP only refreshes N, Z and L; C and F keep their previous values.
   localparam logic [4:0] CMP_MASK = 5'b11010;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t             state_reg, state_next;
   logic [4:0]         op_reg;
   logic [RF_AW-1:0]   rdest_reg;
   logic [RF_AW-1:0]   rsrc_reg;
   logic [DATA_W-1:0]  imm_reg;
   logic               use_imm_reg;
   logic [SHAMT_W-1:0] shamt_reg;
   logic [SHAMT_W-1:0] cnt_reg;
   logic [DATA_W-1:0]  s_reg;
   logic [DATA_W-1:0]  d_reg;
   logic [DATA_W-1:0]  r_reg;
   logic [4:0]         fl_reg;
   logic [4:0]         psr_reg;
   logic [4:0]         psr_next;
   logic [DATA_W-1:0]  src_operand;
   logic               op_illegal;
   logic               op_shift;

   assign op_illegal  = (op_reg > OP_ARSH);
   assign op_shift    = (op_reg >= OP_LSH) && (op_reg <= OP_ARSH);
   assign src_operand = use_imm_reg ? imm_reg : rf_rdata_a;

   assign rf_raddr_a = rsrc_reg;
   assign rf_raddr_b = rdest_reg;
   assign rf_waddr   = rdest_reg;
   assign rf_wdata   = r_reg;
   assign psr        = psr_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_psr
         assign psr_next[gi] = ((state_reg == WB) &&
                                ((op_reg == OP_ADD) || (op_reg == OP_SUB) ||
                                 ((op_reg == OP_CMP) && CMP_MASK[gi])))
                               ? fl_reg[gi] : psr_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      req.req_ready = 1'b0;
      req.done      = 1'b0;
      req.err       = 1'b0;
      rf_we         = 1'b0;
      alu_op        = '0;
      alu_rsrc      = '0;
      alu_rdest     = '0;
      case (state_reg)
         IDLE: begin
            req.req_ready = !reset;
            if (req.req_valid) state_next = READ;
         end
         READ: begin
            if (op_illegal || (op_shift && (shamt_reg == '0)))
               state_next = WB;
            else
               state_next = EXEC;
         end
         EXEC: begin
            alu_op    = op_reg;
            alu_rsrc  = s_reg;
            alu_rdest = d_reg;
            if (!op_shift || (cnt_reg == SHAMT_W'(1)))
               state_next = WB;
         end
         WB: begin
            // Gated by reset so an abort during WB leaves no write behind.
            req.done   = !reset;
            req.err    = !reset && op_illegal;
            rf_we      = !reset && !op_illegal && (op_reg != OP_CMP);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         psr_reg     <= '0;
         op_reg      <= '0;
         rdest_reg   <= '0;
         rsrc_reg    <= '0;
         imm_reg     <= '0;
         use_imm_reg <= 1'b0;
         shamt_reg   <= '0;
         cnt_reg     <= '0;
         s_reg       <= '0;
         d_reg       <= '0;
         r_reg       <= '0;
         fl_reg      <= '0;
      end else begin
         state_reg <= state_next;
         psr_reg   <= psr_next;
         case (state_reg)
            IDLE: begin
               if (req.req_valid) begin
                  op_reg      <= req.req_op;
                  rdest_reg   <= req.req_rdest;
                  rsrc_reg    <= req.req_rsrc;
                  imm_reg     <= req.req_imm;
                  use_imm_reg <= req.req_use_imm;
                  shamt_reg   <= req.req_shamt;
               end
            end
            READ: begin
               s_reg   <= src_operand;
               d_reg   <= rf_rdata_b;
               cnt_reg <= shamt_reg;
               // A zero-length shift writes S back unchanged.
               r_reg   <= src_operand;
               fl_reg  <= '0;
            end
            EXEC: begin
               if (op_shift) begin
                  s_reg   <= alu_out;
                  cnt_reg <= cnt_reg - SHAMT_W'(1);
                  if (cnt_reg == SHAMT_W'(1)) r_reg <= alu_out;
               end else begin
                  r_reg  <= alu_out;
                  fl_reg <= alu_flags;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomized bench for alu_exec_ctrl with a bench-side ALU, register file and
// an operation-level reference model of results, flags, latency and writes.
module tb_alu_exec_ctrl;
   localparam int DATA_W  = 16;
   localparam int RF_AW   = 4;
   localparam int SHAMT_W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_exec_ctrl_if #(.DATA_W(DATA_W), .RF_AW(RF_AW), .SHAMT_W(SHAMT_W)) req_if ();

   logic [RF_AW-1:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
   logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
   logic              rf_we;
   logic [DATA_W-1:0] alu_rsrc, alu_rdest, alu_out;
   logic [4:0]        alu_op, alu_flags, psr;

   alu_exec_ctrl #(.DATA_W(DATA_W), .RF_AW(RF_AW), .SHAMT_W(SHAMT_W)) dut (
      .clk(clk), .reset(reset), .req(req_if),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .alu_rsrc(alu_rsrc), .alu_rdest(alu_rdest), .alu_op(alu_op),
      .alu_out(alu_out), .alu_flags(alu_flags), .psr(psr)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Stand-in ALU: one pass per cycle, flags {N,Z,F,L,C}.
   function automatic logic [15:0] alu_step(input logic [4:0] op, input logic [15:0] s, input logic [15:0] d);
      case (op)
         5'd0:       return d + s;
         5'd1, 5'd2: return d - s;
         5'd3:       return d & s;
         5'd4:       return d | s;
         5'd5:       return d ^ s;
         5'd6:       return ~s;
         5'd7:       return {s[14:0], 1'b0};
         5'd8:       return {1'b0, s[15:1]};
         5'd9:       return {s[15], s[15:1]};
         default:    return 16'h0000;
      endcase
   endfunction

   function automatic logic [4:0] alu_flg(input logic [4:0] op, input logic [15:0] s, input logic [15:0] d);
      logic [16:0] t;
      logic c, f, l, z, n;
      if (op == 5'd0) t = {1'b0, d} + {1'b0, s};
      else            t = {1'b0, d} + {1'b0, ~s} + 17'd1;
      c = t[16];
      if (op == 5'd0) f = (d[15] == s[15]) && (t[15] != d[15]);
      else            f = (d[15] != s[15]) && (t[15] != d[15]);
      l = d < s;
      z = d == s;
      n = $signed(d) < $signed(s);
      return {n, z, f, l, c};
   endfunction

   always_comb begin
      alu_out   = alu_step(alu_op, alu_rsrc, alu_rdest);
      alu_flags = alu_flg(alu_op, alu_rsrc, alu_rdest);
   end

   logic [15:0] rf [16];
   logic        pre_we = 1'b0;
   logic [3:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;
   int          we_count = 0;

   assign rf_rdata_a = rf[rf_raddr_a];
   assign rf_rdata_b = rf[rf_raddr_b];

   always_ff @(posedge clk) begin
      if (pre_we) rf[pre_addr] <= pre_data;
      else if (rf_we) begin
         rf[rf_waddr] <= rf_wdata;
         we_count     <= we_count + 1;
      end
   end

   // Reference model state
   logic [15:0] exp_rf [16];
   logic [4:0]  exp_psr = 5'b0;

   function automatic logic [15:0] ref_result(input logic [4:0] op, input logic [15:0] s,
                                               input logic [15:0] d, input logic [3:0] sh);
      logic signed [15:0] ss;
      ss = s;
      case (op)
         5'd7:    return s << sh;
         5'd8:    return s >> sh;
         5'd9:    return ss >>> sh;
         default: return alu_step(op, s, d);
      endcase
   endfunction

   function automatic logic [15:0] rf_xsum();
      logic [15:0] x = '0;
      for (int i = 0; i < 16; i++) x ^= rf[i];
      return x;
   endfunction

   function automatic logic [15:0] exp_xsum();
      logic [15:0] x = '0;
      for (int i = 0; i < 16; i++) x ^= exp_rf[i];
      return x;
   endfunction

   task automatic preload(input logic [3:0] a, input logic [15:0] v);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = v;
      @(negedge clk);
      pre_we = 1'b0;
      exp_rf[a] = v;
   endtask

   task automatic drive_req(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [15:0] imm, input logic ui, input logic [3:0] sh);
      req_if.req_op = op; req_if.req_rdest = rd; req_if.req_rsrc = rs;
      req_if.req_imm = imm; req_if.req_use_imm = ui; req_if.req_shamt = sh;
      req_if.req_valid = 1'b1;
   endtask

   // Issues one request (called at a negedge in IDLE) and checks its outcome.
   task automatic do_op(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [15:0] imm, input logic ui, input logic [3:0] sh);
      logic [15:0] s, d, res;
      logic        illegal, shift, exp_we;
      int          exp_lat, lat, we0;
      s       = ui ? imm : exp_rf[rs];
      d       = exp_rf[rd];
      illegal = op > 5'd9;
      shift   = (op >= 5'd7) && (op <= 5'd9);
      res     = ref_result(op, s, d, sh);
      exp_we  = !illegal && (op != 5'd2);
      exp_lat = illegal ? 2 : (shift ? 2 + int'(sh) : 3);
      if (exp_we) exp_rf[rd] = res;
      if (op == 5'd0 || op == 5'd1) exp_psr = alu_flg(op, s, d);
      else if (op == 5'd2) begin
         logic [4:0] fl;
         fl = alu_flg(op, s, d);
         exp_psr = {fl[4], fl[3], exp_psr[2], fl[1], exp_psr[0]};
      end

      chk("ready_idle", 32'(req_if.req_ready), 32'd1);
      drive_req(op, rd, rs, imm, ui, sh);
      we0 = we_count;
      @(posedge clk);
      @(negedge clk);
      req_if.req_valid = 1'b0;
      lat = 1;
      while (!req_if.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("err", 32'(req_if.err), 32'(illegal));
      @(negedge clk);
      chk("we_count", 32'(we_count - we0), 32'(exp_we));
      chk("rf_dest", 32'(rf[rd]), 32'(exp_rf[rd]));
      chk("rf_xsum", 32'(rf_xsum()), 32'(exp_xsum()));
      chk("psr", 32'(psr), 32'(exp_psr));
      $display("op=%0d rd=%0d rs=%0d imm=%h ui=%0d sh=%0d res=%h psr=%b lat=%0d",
               op, rd, rs, imm, ui, sh, rf[rd], psr, lat);
   endtask

   initial begin
      logic [4:0] rop;
      int         lat, we0;
      reset = 1'b1;
      req_if.req_valid = 1'b0;
      drive_req(5'd0, 4'd0, 4'd0, 16'h0, 1'b0, 4'd0);
      req_if.req_valid = 1'b0;
      for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
      chk("rst_ready", 32'(req_if.req_ready), 32'd0);
      chk("rst_done", 32'(req_if.done), 32'd0);
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_psr", 32'(psr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Directed scenarios
      preload(4'd1, 16'h7FFF); preload(4'd2, 16'h0001);
      do_op(5'd0, 4'd1, 4'd2, 16'h0, 1'b0, 4'd0);
      chk("t1_r1", 32'(rf[1]), 32'h8000);
      chk("t1_psr", 32'(psr), 32'b00100);

      preload(4'd3, 16'h0005);
      do_op(5'd1, 4'd3, 4'd0, 16'h0003, 1'b1, 4'd0);
      chk("t2_r3", 32'(rf[3]), 32'h0002);
      chk("t2_psr", 32'(psr), 32'b00001);

      preload(4'd4, 16'h0001); preload(4'd5, 16'hFFFF);
      do_op(5'd2, 4'd4, 4'd5, 16'h0, 1'b0, 4'd0);
      chk("t3_r4", 32'(rf[4]), 32'h0001);
      chk("t3_psr", 32'(psr), 32'b00011);

      preload(4'd6, 16'h8010);
      do_op(5'd9, 4'd7, 4'd6, 16'h0, 1'b0, 4'd4);
      chk("t4_arsh", 32'(rf[7]), 32'hF801);
      do_op(5'd7, 4'd8, 4'd6, 16'h0, 1'b0, 4'd0);
      chk("t4_lsh0", 32'(rf[8]), 32'h8010);

      do_op(5'b01111, 4'd9, 4'd6, 16'h0, 1'b0, 4'd0);
      chk("t5_psr", 32'(psr), 32'b00011);

      // Abort a long shift with reset in its fifth cycle
      do_op(5'd0, 4'd1, 4'd2, 16'h0, 1'b0, 4'd0);
      drive_req(5'd8, 4'd10, 4'd6, 16'h0, 1'b0, 4'd15);
      we0 = we_count;
      @(posedge clk);
      @(negedge clk);
      req_if.req_valid = 1'b0;
      lat = 1;
      while (lat < 5) begin
         @(negedge clk);
         lat++;
      end
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready_in_rst", 32'(req_if.req_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("abort_ready", 32'(req_if.req_ready), 32'd1);
      exp_psr = 5'b0;
      chk("abort_psr", 32'(psr), 32'd0);
      for (int i = 0; i < 20; i++) @(negedge clk);
      chk("abort_no_we", 32'(we_count - we0), 32'd0);
      chk("abort_rf", 32'(rf_xsum()), 32'(exp_xsum()));
      $display("op=8 aborted by reset at cycle %0d psr=%b", lat, psr);
      do_op(5'd0, 4'd11, 4'd12, 16'h0, 1'b0, 4'd0);

      // Randomized operations
      for (int n = 0; n < 150; n++) begin
         rop = 5'($urandom_range(0, 11));
         if (rop > 5'd9) rop = 5'($urandom_range(10, 31));
         do_op(rop, 4'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
